nibble_serial_adder: RTL
========================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001: Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002: Derived constant NIB = WIDTH/4 SHALL be the number of 4-bit slices processed per operation.
REQ-003: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: start  input  1  request to begin an addition, sampled on a rising clk edge.
REQ-006: a  input  WIDTH  operand A, captured when start is accepted.
REQ-007: b  input  WIDTH  operand B, captured when start is accepted.
REQ-008: cin  input  1  carry-in, captured when start is accepted.
REQ-009: busy  output  1  high while slices are being computed.
REQ-010: done  output  1  one-cycle pulse when the result becomes valid.
REQ-011: s  output  WIDTH  registered sum.
REQ-012: cout  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-013: FSM states SHALL be IDLE, RUN and DONE.
REQ-014: start SHALL be accepted only in IDLE or DONE; accepting it captures a, b and cin, clears the slice index and the partial sum, and moves the FSM to RUN.
REQ-015: In RUN, each edge SHALL add one 4-bit slice, LSB slice first, using 4-bit carry-lookahead logic (g = a&b, p = a^b, carries from g/p, no ripple chain); the slice carry-out SHALL be registered as the carry-in of the next slice.
REQ-016: The edge that processes slice NIB-1 SHALL load s and cout and move the FSM to DONE.
REQ-017: done SHALL be 1 only in DONE; the latency from the accepting edge to the edge that raises done SHALL be exactly NIB edges (4 edges for WIDTH=16).
REQ-018: From DONE, the FSM SHALL go to RUN if start=1 (back-to-back), otherwise to IDLE.
REQ-019: busy SHALL equal 1 exactly in RUN.
REQ-020: start in RUN SHALL be ignored; captured operands and progress SHALL be unaffected.
REQ-021: Changes on a, b and cin while not accepting SHALL NOT affect the operation in flight.
REQ-022: s and cout SHALL hold their last result in IDLE and RUN and change only on the final slice edge.
REQ-023: Arithmetic is unsigned modulo 2^WIDTH; {cout, s} SHALL equal a + b + cin.

Reset
REQ-024: When rst=1 at an edge, the FSM SHALL go to IDLE, with busy=0, done=0, s=0, cout=0, the internal carry=0 and the slice index=0.
REQ-025: rst SHALL take priority over start, and reset during RUN SHALL abandon the operation with no done pulse.

Configuration
REQ-026: Macro NIBBLE_SERIAL_ADDER_OVF_EN: when defined, an output port ovf (1 bit) SHALL exist, be loaded on the final slice edge with signed two's-complement overflow (carry into MSB XOR carry out of MSB), hold like s, and reset to 0.
REQ-027: When the macro is undefined, the port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028: WIDTH=16; start with a=0x1234, b=0x4321, cin=0 -> busy high for 4 cycles, then done=1 for one cycle, s=0x5555, cout=0.
REQ-029: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1 (carry crosses all slices); then a=0xFFFF, b=0xFFFF, cin=1 -> s=0xFFFF, cout=1.
REQ-030: Start 0x0F0F+0x00F1; pulse start with a=0xAAAA on the 2nd RUN cycle -> result is s=0x1000, cout=0, and done pulses exactly once.
REQ-031: Back-to-back: start held high through DONE with 0x0001+0x0001 then 0x8000+0x8000 -> s=0x0002, then s=0x0000 with cout=1, with done pulses 5 edges apart.
REQ-032: Assert rst on the 3rd RUN cycle -> next cycle busy=0, done=0, s=0, cout=0, and no done pulse follows; a new start afterwards produces a correct result.
REQ-033: With NIBBLE_SERIAL_ADDER_OVF_EN: 0x7FFF+0x0001 -> ovf=1, s=0x8000; 0xFFFF+0x0001 -> ovf=0, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial unsigned adder, one 4-bit carry-lookahead slice per clock
// Optional signed-overflow output ovf is enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;
  logic       w_c4;
  logic [3:0] w_sum;
  logic       w_last;

  // Operands shift right each slice, so the active slice is always bits [3:0].
  assign w_g = r_a[3:0] & r_b[3:0];
  assign w_p = r_a[3:0] ^ r_b[3:0];

  assign w_c[0] = r_c;
  assign w_c[1] = w_g[0] | (w_p[0] & r_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & r_c);
  assign w_c4   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_c);

  assign w_sum  = w_p ^ w_c;
  assign w_last = (r_idx == IW'(NIB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_c     <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_acc   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          // Partial sum fills from the top so it is aligned after NIB slices.
          r_acc <= {w_sum, r_acc[WIDTH-1:4]};
          r_a   <= {4'b0000, r_a[WIDTH-1:4]};
          r_b   <= {4'b0000, r_b[WIDTH-1:4]};
          r_c   <= w_c4;
          if (w_last) begin
            r_s     <= {w_sum, r_acc[WIDTH-1:4]};
            r_cout  <= w_c4;
            r_ovf   <= w_c[3] ^ w_c4;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign s    = r_s;
  assign cout = r_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf  = r_ovf;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = r_ovf;
`endif

endmodule
